display_buffer_sequencer: RTL and testbench

Sequences the LED tile's double-buffered display RAM. It turns the CPU's PIO addr/data/ctrl exports into committed RAM writes, bank swaps and bank clears. It arbitrates the single RAM port between the real-time scan engine (reads, front bank) and CPU-originated writes/clears (back bank). It returns handshake status to the CPU through a PIO input.

---
 rtl/display_buffer_pkg.sv | 17 +
 rtl/toggle_req_detect.sv | 24 ++
 rtl/display_buffer_sequencer.sv | 139 +++++++++++++
 tb/tb_display_buffer_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/display_buffer_pkg.sv
// display_buffer_pkg: shared constants and types for the display buffer sequencer
package display_buffer_pkg;
  localparam int CTRL_WR      = 0;
  localparam int CTRL_SWAP    = 1;
  localparam int CTRL_CLR     = 2;
  localparam int CTRL_OVR_CLR = 3;
  localparam int STAT_WR_ACK    = 0;
  localparam int STAT_SWAP_ACK  = 1;
  localparam int STAT_CLR_DONE  = 2;
  localparam int STAT_OVERRUN   = 3;
  localparam int STAT_WR_PEND   = 4;
  localparam int STAT_SWAP_PEND = 5;
  localparam int STAT_CLEARING  = 6;
  localparam int STAT_FRONT     = 7;
  typedef enum logic {IDLE, CLEAR} state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_SCAN, GNT_WR, GNT_CLR} gnt_e;
endpackage

// File: rtl/toggle_req_detect.sv
// toggle_req_detect: per-bit change detector that flags a request whenever an input bit toggles
// Ports: clk_i/rst_i clock and async active-high reset, sig_i monitored bus, req_o one-cycle request per changed bit.
// The first cycle after reset only captures sig_i, so a bus held non-zero through reset raises nothing.
module toggle_req_detect #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] sig_i,
  output logic [W-1:0] req_o
);
  logic         init_q;
  logic [W-1:0] prev_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_q <= 1'b0;
      prev_q <= '0;
    end else begin
      init_q <= 1'b1;
      prev_q <= sig_i;
    end
  end
  always_comb req_o = init_q ? (sig_i ^ prev_q) : '0;
endmodule

// File: rtl/display_buffer_sequencer.sv
// display_buffer_sequencer: arbitrates the double-buffered display RAM between scan reads and CPU writes/clears/swaps
// Ports: clk_clk/reset_reset clock and async active-high reset; pio_addr/pio_data/pio_ctrl CPU toggle-request exports;
//   pio_status handshake back to the CPU; scan_* real-time read port on the front bank; ram_* single registered RAM port.
module display_buffer_sequencer
  import display_buffer_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] pio_addr,
  input  logic [DATA_W-1:0] pio_data,
  input  logic [CTRL_W-1:0] pio_ctrl,
  output logic [7:0]        pio_status,
  input  logic              scan_rd_req,
  input  logic [ADDR_W-1:0] scan_rd_addr,
  input  logic              scan_frame_start,
  output logic              scan_rd_valid,
  output logic [DATA_W-1:0] scan_rd_data,
  output logic [ADDR_W:0]   ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);
  logic [CTRL_W-1:0] req;
  logic              unused_rsvd;
  gnt_e              gnt;
  logic              do_swap, clr_last, wr_take, wr_drop;
  state_e            state_q, state_d;
  logic              front_q, front_d;
  logic              wr_pend_q, wr_pend_d;
  logic              swap_pend_q, swap_pend_d;
  logic              ovr_q, ovr_d;
  logic              wr_ack_q, wr_ack_d;
  logic              swap_ack_q, swap_ack_d;
  logic              clr_done_q, clr_done_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic              rd_pipe_q, rd_pipe_d;
  logic              rd_valid_q;
  logic [7:0]        status_q, status_d;
  toggle_req_detect #(.W(CTRL_W)) u_req (
    .clk_i (clk_clk),
    .rst_i (reset_reset),
    .sig_i (pio_ctrl),
    .req_o (req)
  );
  assign unused_rsvd = ^req[CTRL_W-1:4];
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    gnt      = scan_rd_req ? GNT_SCAN : wr_pend_q ? GNT_WR : (state_q == CLEAR) ? GNT_CLR : GNT_NONE;
    clr_last = (gnt == GNT_CLR) && (&clr_cnt_q);
    state_d  = (state_q == IDLE) ? (req[CTRL_CLR] ? CLEAR : IDLE) : (clr_last ? IDLE : CLEAR);
  end
  // A swap only lands at a frame boundary with no write still queued and no clear running,
  // so the newly exposed bank is complete when scan starts reading it.
  always_comb begin
    do_swap     = scan_frame_start & swap_pend_q & ~wr_pend_q & (state_q == IDLE);
    wr_take     = req[CTRL_WR] & ~wr_pend_q;
    wr_drop     = req[CTRL_WR] & wr_pend_q;
    wr_pend_d   = wr_take | (wr_pend_q & (gnt != GNT_WR));
    wr_addr_d   = wr_take ? pio_addr : wr_addr_q;
    wr_data_d   = wr_take ? pio_data : wr_data_q;
    ovr_d       = wr_drop | (ovr_q & ~req[CTRL_OVR_CLR]);
    wr_ack_d    = wr_ack_q ^ (gnt == GNT_WR);
    swap_pend_d = req[CTRL_SWAP] | (swap_pend_q & ~do_swap);
    front_d     = front_q ^ do_swap;
    swap_ack_d  = swap_ack_q ^ do_swap;
    clr_cnt_d   = (state_q == IDLE) ? '0 : clr_cnt_q + ADDR_W'(gnt == GNT_CLR);
    clr_done_d  = clr_done_q ^ clr_last;
    ram_addr_d  = (gnt == GNT_SCAN) ? {front_q, scan_rd_addr} :
                  (gnt == GNT_WR)   ? {~front_q, wr_addr_q} :
                  (gnt == GNT_CLR)  ? {~front_q, clr_cnt_q} : ram_addr_q;
    ram_wdata_d = (gnt == GNT_WR) ? wr_data_q : (gnt == GNT_CLR) ? '0 : ram_wdata_q;
    ram_we_d    = (gnt == GNT_WR) || (gnt == GNT_CLR);
    rd_pipe_d   = (gnt == GNT_SCAN);
    status_d                 = '0;
    status_d[STAT_WR_ACK]    = wr_ack_q;
    status_d[STAT_SWAP_ACK]  = swap_ack_q;
    status_d[STAT_CLR_DONE]  = clr_done_q;
    status_d[STAT_OVERRUN]   = ovr_q;
    status_d[STAT_WR_PEND]   = wr_pend_q;
    status_d[STAT_SWAP_PEND] = swap_pend_q;
    status_d[STAT_CLEARING]  = (state_q == CLEAR);
    status_d[STAT_FRONT]     = front_q;
  end
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      front_q     <= 1'b0;
      wr_pend_q   <= 1'b0;
      swap_pend_q <= 1'b0;
      ovr_q       <= 1'b0;
      wr_ack_q    <= 1'b0;
      swap_ack_q  <= 1'b0;
      clr_done_q  <= 1'b0;
      clr_cnt_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      rd_pipe_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      status_q    <= '0;
    end else begin
      front_q     <= front_d;
      wr_pend_q   <= wr_pend_d;
      swap_pend_q <= swap_pend_d;
      ovr_q       <= ovr_d;
      wr_ack_q    <= wr_ack_d;
      swap_ack_q  <= swap_ack_d;
      clr_done_q  <= clr_done_d;
      clr_cnt_q   <= clr_cnt_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      rd_pipe_q   <= rd_pipe_d;
      rd_valid_q  <= rd_pipe_q;
      status_q    <= status_d;
    end
  end
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign ram_we        = ram_we_q;
  assign scan_rd_valid = rd_valid_q;
  assign scan_rd_data  = ram_rdata;
  assign pio_status    = status_q;
endmodule

// File: tb/tb_display_buffer_sequencer.sv
// tb_display_buffer_sequencer: directed self-checking bench for display_buffer_sequencer
module tb_display_buffer_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] addr;
  logic [31:0] data;
  logic [7:0]  ctrl;
  logic [7:0]  status;
  logic        scan_req;
  logic [10:0] scan_addr;
  logic        fs;
  logic        valid;
  logic [31:0] sdata;
  logic [11:0] ram_addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  int tests = 0;
  int fails = 0;
  int bad;
  display_buffer_sequencer dut (
    .clk_clk          (clk),
    .reset_reset      (rst),
    .pio_addr         (addr),
    .pio_data         (data),
    .pio_ctrl         (ctrl),
    .pio_status       (status),
    .scan_rd_req      (scan_req),
    .scan_rd_addr     (scan_addr),
    .scan_frame_start (fs),
    .scan_rd_valid    (valid),
    .scan_rd_data     (sdata),
    .ram_addr         (ram_addr),
    .ram_wdata        (wdata),
    .ram_we           (we),
    .ram_rdata        (rdata)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end
  initial begin
    rst = 1'b1; ctrl = 8'h07; addr = '0; data = '0;
    scan_req = 1'b0; scan_addr = '0; fs = 1'b0; rdata = 32'hCAFE_0001;
    repeat (3) tick();
    chk("rst_status", status, 8'h00);
    chk("rst_we", we, 1'b0);
    chk("rst_addr", ram_addr, 12'h000);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("init_we", we, 1'b0);
      chk("init_status", status, 8'h00);
    end
    addr = 11'h123; data = 32'hDEAD_BEEF; ctrl ^= 8'h01;
    tick();
    chk("wr_latency_we", we, 1'b0);
    tick();
    chk("wr_we", we, 1'b1);
    chk("wr_addr", ram_addr, 12'h923);
    chk("wr_data", wdata, 32'hDEAD_BEEF);
    chk("wr_pend_status", status, 8'h10);
    tick();
    chk("wr_we_off", we, 1'b0);
    chk("wr_addr_hold", ram_addr, 12'h923);
    chk("wr_ack_status", status, 8'h01);
    addr = 11'h055; data = 32'h1111_2222; ctrl ^= 8'h01;
    for (int i = 0; i < 12; i++) begin
      scan_req = (i < 10);
      scan_addr = 11'(i);
      tick();
      if (i < 10) chk("scan_addr", ram_addr, {1'b0, 11'(i)});
      chk("scan_we", we, (i == 10));
      chk("scan_valid", valid, (i >= 1 && i <= 10));
      if (i == 10) begin
        chk("scan_wr_addr", ram_addr, 12'h855);
        chk("scan_wr_data", wdata, 32'h1111_2222);
      end
    end
    chk("scan_status", status, 8'h00);
    rdata = 32'h1234_5678;
    #1;
    chk("scan_passthru", sdata, 32'h1234_5678);
    scan_req = 1'b1; addr = 11'h0AA; data = 32'hA5A5_A5A5; ctrl ^= 8'h01;
    tick();
    addr = 11'h0BB; data = 32'h5A5A_5A5A; ctrl ^= 8'h01;
    tick();
    tick();
    chk("ovr_status", status, 8'h18);
    scan_req = 1'b0;
    tick();
    chk("ovr_first_we", we, 1'b1);
    chk("ovr_first_addr", ram_addr, 12'h8AA);
    chk("ovr_first_data", wdata, 32'hA5A5_A5A5);
    ctrl ^= 8'h08;
    tick();
    chk("ovr_no_second_we", we, 1'b0);
    chk("ovr_still_set", status, 8'h09);
    tick();
    chk("ovr_cleared", status, 8'h01);
    chk("ovr_no_second_we2", we, 1'b0);
    ctrl ^= 8'h02;
    tick();
    fs = 1'b1;
    tick();
    chk("swap_pend_status", status, 8'h21);
    fs = 1'b0;
    tick();
    chk("swap_done_status", status, 8'h83);
    scan_req = 1'b1; addr = 11'h0CC; data = 32'h0BAD_F00D; ctrl ^= 8'h03;
    tick();
    fs = 1'b1;
    tick();
    fs = 1'b0; scan_req = 1'b0;
    tick();
    chk("defer_wr_we", we, 1'b1);
    chk("defer_wr_addr", ram_addr, 12'h0CC);
    chk("defer_status", status, 8'hB3);
    tick();
    chk("defer_still_pend", status, 8'hA2);
    fs = 1'b1;
    tick();
    fs = 1'b0;
    tick();
    chk("defer_swapped", status, 8'h00);
    ctrl ^= 8'h04;
    tick();
    chk("clr_start_we", we, 1'b0);
    bad = 0;
    for (int j = 0; j < 2048; j++) begin
      tick();
      if (j == 0) chk("clr_busy", status[6], 1'b1);
      if (we !== 1'b1 || ram_addr !== {1'b1, 11'(j)} || wdata !== 32'h0) bad++;
    end
    chk("clr_sequence", bad, 0);
    tick();
    chk("clr_end_we", we, 1'b0);
    chk("clr_done_status", status, 8'h04);
    ctrl ^= 8'h04;
    tick();
    for (int j = 0; j < 1000; j++) tick();
    chk("clr_mid_addr", ram_addr, 12'hBE7);
    chk("clr_mid_we", we, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_we", we, 1'b0);
    chk("abort_addr", ram_addr, 12'h000);
    chk("abort_status", status, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_abort_we", we, 1'b0);
      chk("post_abort_status", status, 8'h00);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
